// File: rtl/operand_pair_loader_v_if.sv
// Stream bundle for operand_pair_loader_v: input word stream and output sum stream.
// The loader uses the slave view; the producer/consumer side uses the master view.
interface operand_pair_loader_v_if #(
    parameter int unsigned W = 8
) ();

    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  out_data,
        input  out_valid,
        output out_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output out_data,
        output out_valid,
        input  out_ready
    );

endinterface

// File: rtl/operand_pair_loader_v.sv
// Pairs consecutive stream words into adder operands, returns the sum as a stream
// and counts hand-offs. Optional carry flag on port ovf when OPERAND_PAIR_LOADER_OVF_EN is defined.
module operand_pair_loader_v #(
    parameter int unsigned W     = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 resetn,
    operand_pair_loader_v_if.slave bus,
    output logic [W-1:0]         x_0,
    output logic [W-1:0]         x_1,
    input  logic [W-1:0]         result,
    output logic [CNT_W-1:0]     pair_cnt
`ifdef OPERAND_PAIR_LOADER_OVF_EN
    ,
    output logic                 ovf
`endif
);

    typedef enum logic [1:0] {
        WAIT_A = 2'd0,
        WAIT_B = 2'd1,
        SUM    = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t state;

    // Words are only taken while an operand slot is open.
    assign bus.in_ready = (state == WAIT_A) || (state == WAIT_B);

    // Operand capture, adder sampling and output hand-off.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= WAIT_A;
            x_0           <= '0;
            x_1           <= '0;
            bus.out_data  <= '0;
            bus.out_valid <= 1'b0;
            pair_cnt      <= '0;
`ifdef OPERAND_PAIR_LOADER_OVF_EN
            ovf           <= 1'b0;
`endif
        end else begin
            case (state)
                WAIT_A: begin
                    if (bus.in_valid) begin
                        x_0   <= bus.in_data;
                        state <= WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (bus.in_valid) begin
                        x_1   <= bus.in_data;
                        state <= SUM;
                    end
                end
                SUM: begin
                    // Operands have been stable for a full cycle; the adder output has settled.
                    bus.out_data  <= result;
                    bus.out_valid <= 1'b1;
`ifdef OPERAND_PAIR_LOADER_OVF_EN
                    ovf           <= (result < x_0);
`endif
                    state         <= HOLD;
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        pair_cnt      <= pair_cnt + CNT_W'(1);
`ifdef OPERAND_PAIR_LOADER_OVF_EN
                        ovf           <= 1'b0;
`endif
                        state         <= WAIT_A;
                    end
                end
                default: state <= WAIT_A;
            endcase
        end
    end

endmodule

// File: tb/tb_operand_pair_loader_v.sv
// Randomized self-checking bench for operand_pair_loader_v; the adder is modelled
// behaviourally and expected sums/counts come from plain arithmetic on the sent words.
`timescale 1ns/1ps
module tb_operand_pair_loader_v;

    logic clk;
    logic resetn;

    operand_pair_loader_v_if #(.W(8)) bus ();
    logic [7:0]  x_0, x_1, result;
    logic [15:0] pair_cnt;

    operand_pair_loader_v_if #(.W(8)) bus_s ();
    logic [7:0]  x0_s, x1_s, res_s;
    logic [3:0]  cnt_s;

`ifdef OPERAND_PAIR_LOADER_OVF_EN
    logic ovf, ovf_s;
`endif

    assign result = 8'(x_0 + x_1);
    assign res_s  = 8'(x0_s + x1_s);

    operand_pair_loader_v #(.W(8), .CNT_W(16)) dut (
        .clk(clk), .resetn(resetn), .bus(bus),
        .x_0(x_0), .x_1(x_1), .result(result), .pair_cnt(pair_cnt)
`ifdef OPERAND_PAIR_LOADER_OVF_EN
        , .ovf(ovf)
`endif
    );

    operand_pair_loader_v #(.W(8), .CNT_W(4)) dut_small (
        .clk(clk), .resetn(resetn), .bus(bus_s),
        .x_0(x0_s), .x_1(x1_s), .result(res_s), .pair_cnt(cnt_s)
`ifdef OPERAND_PAIR_LOADER_OVF_EN
        , .ovf(ovf_s)
`endif
    );

    int          checks   = 0;
    int          failures = 0;
    logic [15:0] exp_cnt  = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic send_word(input logic [7:0] d, input int gap, output bit ok);
        ok = 1'b0;
        bus.in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (bus.in_ready) begin
                @(negedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
    endtask

    // Waits for out_valid, holds out_ready low for 'stall' cycles with optional junk input, then accepts.
    task automatic get_sum(input int stall, input bit junk,
                           output logic [7:0] sum, output logic ovf_o, output bit stable,
                           output int lat, output logic [15:0] cnt_hold, output bit ok);
        ok = 1'b0; stable = 1'b1; lat = 0; sum = '0; ovf_o = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_valid  = junk;
        bus.in_data   = 8'($urandom);
        while (!bus.out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        cnt_hold = pair_cnt;
        if (!bus.out_valid) return;
        sum = bus.out_data;
`ifdef OPERAND_PAIR_LOADER_OVF_EN
        ovf_o = ovf;
`endif
        for (int i = 0; i < stall; i++) begin
            bus.in_data = 8'($urandom);
            @(negedge clk);
            if (bus.out_data !== sum || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0)
                stable = 1'b0;
`ifdef OPERAND_PAIR_LOADER_OVF_EN
            if (ovf !== ovf_o) stable = 1'b0;
`endif
        end
        cnt_hold = pair_cnt;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        ok = (bus.out_valid === 1'b0);
    endtask

    // Full pair with every observable checked against the arithmetic model.
    task automatic run_pair(input string tag, input logic [7:0] a, input logic [7:0] b,
                            input int gap_a, input int gap_b, input int stall, input bit junk);
        bit ok_a, ok_b, ok_o, stable;
        logic [7:0] sum; logic ovf_o; int lat; logic [15:0] cnt_hold;
        logic [8:0] full;
        full = 9'(a) + 9'(b);
        send_word(a, gap_a, ok_a);
        send_word(b, gap_b, ok_b);
        checks++;
        if (!(ok_a && ok_b)) begin failures++; $display("FAIL %s accept: got %0d%0d want 11", tag, ok_a, ok_b); end
        get_sum(stall, junk, sum, ovf_o, stable, lat, cnt_hold, ok_o);
        checks++;
        if (lat !== 1) begin failures++; $display("FAIL %s latency: got %0d want 1", tag, lat); end
        checks++;
        if (sum !== full[7:0]) begin failures++; $display("FAIL %s sum: got %0h want %0h", tag, sum, full[7:0]); end
`ifdef OPERAND_PAIR_LOADER_OVF_EN
        checks++;
        if (ovf_o !== full[8]) begin failures++; $display("FAIL %s ovf: got %0b want %0b", tag, ovf_o, full[8]); end
`endif
        checks++;
        if (!stable) begin failures++; $display("FAIL %s hold_stable: got 0 want 1", tag); end
        checks++;
        if (cnt_hold !== exp_cnt) begin failures++; $display("FAIL %s cnt_before: got %0h want %0h", tag, cnt_hold, exp_cnt); end
        exp_cnt = exp_cnt + 16'd1;
        checks++;
        if (!ok_o) begin failures++; $display("FAIL %s valid_drop: got 1 want 0", tag); end
        checks++;
        if (pair_cnt !== exp_cnt) begin failures++; $display("FAIL %s pair_cnt: got %0h want %0h", tag, pair_cnt, exp_cnt); end
        checks++;
        if (x_0 !== a || x_1 !== b) begin failures++; $display("FAIL %s operands: got %0h/%0h want %0h/%0h", tag, x_0, x_1, a, b); end
        checks++;
        if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL %s ready_after: got %0b want 1", tag, bus.in_ready); end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        exp_cnt = '0;
        @(negedge clk);
        checks++;
        if (x_0 !== 8'h00 || x_1 !== 8'h00 || bus.out_data !== 8'h00 || pair_cnt !== 16'h0) begin
            failures++;
            $display("FAIL reset_regs: got %0h/%0h/%0h/%0h want 0/0/0/0", x_0, x_1, bus.out_data, pair_cnt);
        end
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_hs: got valid=%0b ready=%0b want valid=0 ready=1", bus.out_valid, bus.in_ready);
        end
`ifdef OPERAND_PAIR_LOADER_OVF_EN
        checks++;
        if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf: got %0b want 0", ovf); end
`endif
    endtask

    task automatic test_basic();
        run_pair("basic", 8'h12, 8'h34, 0, 0, 0, 1'b0);
    endtask

    task automatic test_carry();
        run_pair("carry", 8'hF0, 8'h20, 0, 0, 0, 1'b0);
        run_pair("nocarry", 8'h01, 8'h02, 0, 0, 0, 1'b0);
    endtask

    task automatic test_stall();
        run_pair("stall", 8'hA5, 8'h3C, 0, 0, 5, 1'b1);
    endtask

    task automatic test_gaps();
        run_pair("gap12", 8'h01, 8'h02, 2, 2, 0, 1'b0);
        run_pair("gap34", 8'h03, 8'h04, 2, 2, 0, 1'b0);
        run_pair("longwait", 8'h77, 8'h99, 0, 9, 1, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++)
            run_pair($sformatf("rnd%0d", i), 8'($urandom), 8'($urandom),
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 4)), 1'($urandom));
    endtask

    task automatic test_reset_mid_pair();
        bit ok;
        bit ok_b;
        logic [7:0] sum; logic ovf_o; bit stable; int lat; logic [15:0] cnt_hold;
        send_word(8'h55, 0, ok);
        #2 resetn = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || x_0 !== 8'h00 || pair_cnt !== 16'h0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_waitb: got v=%0b x0=%0h cnt=%0h r=%0b want v=0 x0=0 cnt=0 r=1",
                     bus.out_valid, x_0, pair_cnt, bus.in_ready);
        end
        @(negedge clk);
        resetn = 1'b1;
        exp_cnt = '0;
        // Second reset with a sum pending in the output register.
        send_word(8'h11, 0, ok);
        send_word(8'h22, 0, ok_b);
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL rst_setup: got %0b want 1", bus.out_valid); end
        #2 resetn = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 || pair_cnt !== 16'h0) begin
            failures++;
            $display("FAIL rst_hold: got v=%0b d=%0h cnt=%0h want 0/0/0", bus.out_valid, bus.out_data, pair_cnt);
        end
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        run_pair("after_rst", 8'h0A, 8'h0B, 0, 0, 0, 1'b0);
        get_sum(0, 1'b0, sum, ovf_o, stable, lat, cnt_hold, ok);
        checks++;
        if (ok || lat < 50) begin failures++; $display("FAIL rst_no_extra: got lat=%0d want 50", lat); end
    endtask

    task automatic test_wrap();
        int hands = 0;
        int cyc   = 0;
        bit seen;
        checks++;
        if (cnt_s !== 4'h0) begin failures++; $display("FAIL wrap_start: got %0h want 0", cnt_s); end
        bus_s.in_valid  = 1'b1;
        bus_s.out_ready = 1'b1;
        while (hands < 17 && cyc < 300) begin
            bus_s.in_data = 8'($urandom);
            seen = bus_s.out_valid;
            @(negedge clk);
            cyc++;
            if (seen) begin
                hands++;
                checks++;
                if (cnt_s !== 4'(hands)) begin
                    failures++;
                    $display("FAIL wrap_cnt%0d: got %0h want %0h", hands, cnt_s, 4'(hands));
                end
            end
        end
        bus_s.in_valid  = 1'b0;
        bus_s.out_ready = 1'b0;
        checks++;
        if (hands !== 17) begin failures++; $display("FAIL wrap_hands: got %0d want 17", hands); end
    endtask

    initial begin
        resetn          = 1'b0;
        bus.in_data     = '0;
        bus.in_valid    = 1'b0;
        bus.out_ready   = 1'b0;
        bus_s.in_data   = '0;
        bus_s.in_valid  = 1'b0;
        bus_s.out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_carry();
        test_stall();
        test_gaps();
        test_random();
        test_reset_mid_pair();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
